// File: rtl/fetch_unit.sv
// Program counter / fetch stage with relative branches, return-address stack and RUN/HALTED control.
// Latency: new PC one cycle after the control inputs are sampled; no backpressure, one action per cycle.
// Build option FETCH_RAS_WRAP_EN: Call on a full RAS overwrites the oldest entry instead of dropping the push.
module fetch_unit #(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] RESET_ADDR = '0,
    parameter logic [PC_W-1:0] PC_INC     = PC_W'(1),
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                             CLK,
    input  logic                             Init_n,
    input  logic                             Start,
    input  logic [PC_W-1:0]                  Start_addr,
    input  logic                             Halt,
    input  logic                             Branch_abs,
    input  logic                             Branch_rel_en,
    input  logic                             Cond_sel,
    input  logic                             ALU_zero,
    input  logic                             Call,
    input  logic                             Ret,
    input  logic [PC_W-1:0]                  Target,
    output logic [PC_W-1:0]                  PC,
    output logic                             Running,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   Ras_depth,
    output logic                             Ras_ovf,
    output logic                             Ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int DW    = $clog2(RAS_DEPTH+1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(RAS_DEPTH);

`ifdef FETCH_RAS_WRAP_EN
    localparam bit RAS_WRAP = 1'b1;
`else
    localparam bit RAS_WRAP = 1'b0;
`endif

    typedef enum logic {HALTED, RUN} state_t;

    state_t            state;
    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;     // next slot to write; top of stack is ras_ptr-1
    logic [PTR_W-1:0]  top_idx;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_rel;
    logic              ras_full;
    logic              ras_empty;
    logic              cond_met;
    logic              push_en;

    assign top_idx   = ras_ptr - 1'b1;
    assign pc_inc    = PC + PC_INC;
    assign pc_rel    = PC + Target;
    assign ras_full  = (Ras_depth == DEPTH_MAX);
    assign ras_empty = (Ras_depth == '0);
    assign cond_met  = Cond_sel ? !ALU_zero : ALU_zero;
    assign push_en   = !Start && (state == RUN) && !Halt && !Ret && Call
                       && (!ras_full || RAS_WRAP);

    // Stack storage carries no reset: depth/pointer define which entries are live.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            ras_mem[ras_ptr] <= pc_inc;
        end
    end

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            PC        <= RESET_ADDR;
            state     <= HALTED;
            Running   <= 1'b0;
            ras_ptr   <= '0;
            Ras_depth <= '0;
            Ras_ovf   <= 1'b0;
            Ras_unf   <= 1'b0;
        end else if (Start) begin
            PC        <= Start_addr;
            state     <= RUN;
            Running   <= 1'b1;
            ras_ptr   <= '0;
            Ras_depth <= '0;
            Ras_ovf   <= 1'b0;
            Ras_unf   <= 1'b0;
        end else if (state == RUN) begin
            if (Halt) begin
                state   <= HALTED;
                Running <= 1'b0;
            end else if (Ret) begin
                if (!ras_empty) begin
                    PC        <= ras_mem[top_idx];
                    ras_ptr   <= top_idx;
                    Ras_depth <= Ras_depth - 1'b1;
                end else begin
                    Ras_unf <= 1'b1;
                    PC      <= pc_inc;
                end
            end else if (Call) begin
                PC <= Target;
                if (ras_full) begin
                    Ras_ovf <= 1'b1;
                    // Wrapping push lands on the oldest slot; depth stays saturated.
                    if (RAS_WRAP) begin
                        ras_ptr <= ras_ptr + 1'b1;
                    end
                end else begin
                    ras_ptr   <= ras_ptr + 1'b1;
                    Ras_depth <= Ras_depth + 1'b1;
                end
            end else if (Branch_abs) begin
                PC <= Target;
            end else if (Branch_rel_en && cond_met) begin
                PC <= pc_rel;
            end else begin
                PC <= pc_inc;
            end
        end
    end

endmodule
